// File: rtl/enc_pkg.sv
// +----------------------------------------------------------------------+
// | enc_pkg: shared encoder FSM state constants and width helper.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package enc_pkg;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prio_enc_comb.sv
// +----------------------------------------------------------------------+
// | prio_enc_comb: combinational rotated priority encoder.               |
// | Search starts at i_base going down and wraps to N-1. Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module prio_enc_comb
  import enc_pkg::*;
#(
  parameter int N = 8,
  localparam int IDW = clog2_f(N)
) (
  input  logic [N-1:0]   i_vec,
  input  logic [IDW-1:0] i_base,
  output logic [IDW-1:0] o_id,
  output logic           o_hit
);

  logic [N-1:0]           w_lo_mask;
  logic [N-1:0]           w_lo;
  logic [N-1:0]           w_sel;
  logic [N-1:0]           w_hi;
  logic [IDW-1:0][N-1:0]  w_bsel;

  // Indices at or below the base outrank the ones above it.
  assign w_lo  = i_vec & w_lo_mask;
  assign w_sel = (|w_lo) ? w_lo : i_vec;
  assign o_hit = |i_vec;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign w_lo_mask[gi] = (IDW'(gi) <= i_base);
      assign w_hi[gi]      = w_sel[gi] & ~(|(w_sel >> (gi + 1)));
    end
    for (genvar gb = 0; gb < IDW; gb++) begin : g_idbit
      for (genvar gi = 0; gi < N; gi++) begin : g_term
        assign w_bsel[gb][gi] = w_hi[gi] & (((gi >> gb) & 1) != 0);
      end
      assign o_id[gb] = |w_bsel[gb];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/prio_irq_encoder.sv
// +----------------------------------------------------------------------+
// | prio_irq_encoder: edge-captured interrupt latch with masked priority |
// | selection and valid/ack handshake. Option: ROUND_ROBIN_EN. Rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

module prio_irq_encoder
  import enc_pkg::*;
#(
  parameter int N = 8,
  localparam int IDW = clog2_f(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   mask,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  input  logic           irq_ack,
  output logic [N-1:0]   pending,
  output logic           any_pend
);

  localparam logic [IDW-1:0] c_LAST_ID = IDW'(N - 1);

  logic [N-1:0]   r_req_q;
  logic [N-1:0]   r_pending;
  logic [0:0]     r_state;
  logic [IDW-1:0] r_irq_id;
  logic           r_any_pend;

  logic [N-1:0]   w_set;
  logic [N-1:0]   w_clr;
  logic [N-1:0]   w_cand;
  logic [IDW-1:0] w_base;
  logic [IDW-1:0] w_win;
  logic           w_hit;
  logic           w_done;

  assign irq_valid = (r_state == S_PRESENT);
  assign irq_id    = r_irq_id;
  assign pending   = r_pending;
  assign any_pend  = r_any_pend;

  assign w_done = irq_valid & irq_ack;
  assign w_set  = req & ~r_req_q;
  assign w_clr  = w_done ? (N'(1) << r_irq_id) : '0;
  assign w_cand = r_pending & ~mask;

  prio_enc_comb #(.N(N)) u_enc (
    .i_vec  (w_cand),
    .i_base (w_base),
    .o_id   (w_win),
    .o_hit  (w_hit)
  );

`ifdef ROUND_ROBIN_EN
  logic [IDW-1:0] r_base;

  // The acked line drops to lowest priority for the next search.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= c_LAST_ID;
    end else if (w_done) begin
      r_base <= (r_irq_id == '0) ? c_LAST_ID : r_irq_id - 1'b1;
    end
  end

  assign w_base = r_base;
`else
  assign w_base = c_LAST_ID;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q    <= '0;
      r_pending  <= '0;
      r_state    <= S_IDLE;
      r_irq_id   <= '0;
      r_any_pend <= 1'b0;
    end else begin
      r_req_q    <= req;
      // Set is ORed after clear so a fresh edge survives its own ack.
      r_pending  <= (r_pending & ~w_clr) | w_set;
      r_any_pend <= |w_cand;
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_state  <= S_PRESENT;
            r_irq_id <= w_win;
          end
        end
        S_PRESENT: begin
          if (irq_ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
